relu_maxpool: RTL and testbench
===============================

Name: relu_maxpool

Overview:
- Stage directly downstream of the 3x3 convolution layer.
- Consumes the three per-filter conv sums (result_0..2, 21-bit) qualified by the conv layer's de_out.
- Applies ReLU to each sum, then a 2x2 stride-2 max pool per channel.
- Emits one pooled pixel per 2x2 block with its own data-enable. This output feeds the next layer's line buffers.

Parameters:
- DATA_W, 21, width of each conv sum in two's complement; also the output width.
- IN_WIDTH, 26, valid samples per input line; samples beyond this count in a line are ignored.
- IN_HEIGHT, 26, input lines per frame.
- POOL_W, IN_WIDTH/2, line-buffer depth in entries, derived (floor).

Ports:
- clk  in  1  clock; all logic on posedge.
- RESET  in  1  synchronous, active-high reset.
- start  in  1  frame enable; low clears all counters and outputs the same as RESET, but the line buffer is left untouched.
- de_in  in  1  input sample valid, driven by the conv layer's de_out.
- in_0, in_1, in_2  in  DATA_W each  signed conv sums, channels 0..2.
- de_out  out  1  pooled sample valid.
- out_0, out_1, out_2  out  DATA_W each  pooled results; unsigned, MSB always 0.
- out_col  out  5  pooled column index 0..POOL_W-1.
- out_row  out  5  pooled row index 0..IN_HEIGHT/2-1.
- frame_done  out  1  one-cycle pulse after the last input line of a frame.

Behaviour:
- Reset, or start low: all outputs 0; col, row, hold registers and de_in_d cleared. Line buffer contents are don't-care after reset.
- ReLU: relu(x) = 0 if x[DATA_W-1]==1, else x. Compares are unsigned on the ReLU values; no widening.
- col counter (0..IN_WIDTH-1):
  - Increments on each de_in=1 cycle while col < IN_WIDTH.
  - Samples with col >= IN_WIDTH are ignored.
- Line end = de_in falling edge (de_in_d=1, de_in=0). On line end: col <= 0; row <= row+1.
- Frame end: when the line that ends is row == IN_HEIGHT-1, row <= 0 and frame_done pulses on the next cycle.
- Horizontal pair handling per channel:
  - Even col: hold <= relu(in).
  - Odd col: hmax = max(hold, relu(in)), combinational.
- Even row, odd col: linebuf[col>>1] <= hmax. No output.
- Odd row, odd col: next cycle de_out=1 and out_k = max(linebuf[col>>1], hmax); out_col = col>>1, out_row = row>>1.
- Latency: exactly 1 clk from the qualifying input sample to de_out.
- de_out low: out_0..2, out_col and out_row are driven to 0.
- Odd IN_WIDTH: the last column is ignored. Odd IN_HEIGHT: the last row is written to the buffer but never output.
- de_in gap mid-line: treated as a line end (col resets, row advances). A short line leaves unfilled buffer entries stale; no error is flagged.
- RESET or start deassertion mid-frame:
  - Takes effect on the next edge and kills any de_out pending for that edge.
  - Row/col restart at 0 with the next de_in.
- de_in and a line end cannot coincide (mutually exclusive by definition).
- Equal values: either operand is returned (the values are identical).
- Line buffer: register array of POOL_W x 3 x DATA_W, combinational read, synchronous write.

Decomposition:
- Shared package: DATA_W, IN_WIDTH, IN_HEIGHT, POOL_W and counter widths, so the conv layer and this block share one source.
- Natural sub-module: relu_maxpool_ch, one per channel, instantiated 3 times.
  - Contains the ReLU, the hold register, its own POOL_W-entry line-buffer slice and the two comparators.
  - Takes col, row parity and the write/output strobes from the shared control in the top block.

Test Plan (IN_WIDTH=4, IN_HEIGHT=4 unless noted; same data on all channels):
- Ramp rows 1,2,3,4 / 5,6,7,8 / 9..12 / 13..16, 2-cycle gaps between lines -> de_out 4 times with outputs 6, 8, 14, 16 at (col,row) = (0,0), (1,0), (0,1), (1,1); each 1 cycle after its input sample; frame_done 1 cycle after the falling edge of line 4.
- All inputs = -5 (21'h1FFFFB) -> four outputs of 0 with de_out still asserted.
- Mixed signs: row0 = -3, 7; row1 = 2, -9; per-channel variety (ch1 negated, ch2 = 0) -> ch0 = 7, ch1 = 9, ch2 = 0.
- IN_WIDTH=5, IN_HEIGHT=5, ramp 1..25 -> outputs 7, 9, 17, 19; column 4 and row 4 never appear; frame_done after line 5.
- RESET asserted during line 3 of frame 1, then a full fresh frame -> no de_out during or after reset until the new frame's line 2; new-frame outputs are correct and unaffected by stale buffer contents.
- de_in drops for 1 cycle after 2 samples of a line -> row advances, col restarts; checker confirms the documented short-line behaviour.

Source files
------------

// File: rtl/relu_maxpool_pkg.sv
// rtl/relu_maxpool_pkg.sv - shared geometry, widths and helpers for relu_maxpool
package relu_maxpool_pkg;

   localparam int DATA_W        = 21;
   localparam int DEF_IN_WIDTH  = 26;
   localparam int DEF_IN_HEIGHT = 26;
   localparam int DEF_POOL_W    = DEF_IN_WIDTH / 2;
   localparam int COL_W         = 5;
   localparam int ROW_W         = 5;

   typedef logic [DATA_W-1:0] sample_t;

   // Negative sums clamp to zero; the result is then treated as unsigned.
   function automatic sample_t relu(input sample_t x);
      return x[DATA_W-1] ? '0 : x;
   endfunction

   // Unsigned max; on a tie either operand is the same value.
   function automatic sample_t umax(input sample_t a, input sample_t b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/relu_maxpool_ch.sv
// rtl/relu_maxpool_ch.sv - per-channel ReLU, horizontal hold, line buffer and 2x2 max
module relu_maxpool_ch import relu_maxpool_pkg::*; #(
   parameter int POOL_W = DEF_POOL_W,
   parameter int IDX_W  = 4
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              load_hold,
   input  logic              wr_en,
   input  logic              out_en,
   input  logic [IDX_W-1:0]  idx,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout
);

   logic [DATA_W-1:0] x_relu;
   logic [DATA_W-1:0] hold;
   logic [DATA_W-1:0] hmax;
   logic [DATA_W-1:0] vmax;
   logic [DATA_W-1:0] linebuf [POOL_W];

   assign x_relu = relu(din);
   assign hmax   = umax(hold, x_relu);
   assign vmax   = umax(linebuf[idx], hmax);

   // Even-column value waits in hold; the pooled result is registered for one cycle.
   always_ff @(posedge clk) begin
      if (clr) begin
         hold <= '0;
         dout <= '0;
      end else begin
         if (load_hold) begin
            hold <= x_relu;
         end
         dout <= out_en ? vmax : '0;
      end
   end

   // Line buffer keeps the even-row horizontal max; deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         linebuf[idx] <= hmax;
      end
   end

endmodule

// File: rtl/relu_maxpool.sv
// rtl/relu_maxpool.sv - ReLU followed by 2x2 stride-2 max pool on three conv channels
module relu_maxpool import relu_maxpool_pkg::*; #(
   parameter int IN_WIDTH  = DEF_IN_WIDTH,
   parameter int IN_HEIGHT = DEF_IN_HEIGHT
) (
   input  logic              clk,
   input  logic              RESET,
   input  logic              start,
   input  logic              de_in,
   input  logic [DATA_W-1:0] in_0,
   input  logic [DATA_W-1:0] in_1,
   input  logic [DATA_W-1:0] in_2,
   output logic              de_out,
   output logic [DATA_W-1:0] out_0,
   output logic [DATA_W-1:0] out_1,
   output logic [DATA_W-1:0] out_2,
   output logic [4:0]        out_col,
   output logic [4:0]        out_row,
   output logic              frame_done
);

   localparam int POOL_W = IN_WIDTH / 2;
   localparam int IDX_W  = (POOL_W > 1) ? $clog2(POOL_W) : 1;

   logic             clr;
   logic [COL_W-1:0] col;
   logic [ROW_W-1:0] row;
   logic             de_in_d;
   logic             accept;
   logic             line_end;
   logic             last_row;
   logic             load_hold;
   logic             wr_en;
   logic             out_en;
   logic [IDX_W-1:0] idx;

   // start low behaves like reset except that the line buffer is left alone.
   assign clr       = RESET | ~start;
   assign accept    = de_in & (col < COL_W'(IN_WIDTH));
   assign line_end  = de_in_d & ~de_in;
   assign last_row  = (row == ROW_W'(IN_HEIGHT - 1));
   assign load_hold = accept & ~col[0] & ~clr;
   assign wr_en     = accept & col[0] & ~row[0] & ~clr;
   assign out_en    = accept & col[0] & row[0] & ~clr;
   assign idx       = col[IDX_W:1];

   // Column/row position tracking; any de_in falling edge closes the line.
   always_ff @(posedge clk) begin
      if (clr) begin
         col        <= '0;
         row        <= '0;
         de_in_d    <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         de_in_d    <= de_in;
         frame_done <= line_end & last_row;
         if (line_end) begin
            col <= '0;
            row <= last_row ? '0 : row + 1'b1;
         end else if (accept) begin
            col <= col + 1'b1;
         end
      end
   end

   // Output strobe and pooled coordinates, zero whenever no pixel is emitted.
   always_ff @(posedge clk) begin
      if (clr) begin
         de_out  <= 1'b0;
         out_col <= '0;
         out_row <= '0;
      end else begin
         de_out  <= out_en;
         out_col <= out_en ? 5'(col >> 1) : '0;
         out_row <= out_en ? 5'(row >> 1) : '0;
      end
   end

   relu_maxpool_ch #(.POOL_W(POOL_W), .IDX_W(IDX_W)) u_ch0 (
      .clk(clk), .clr(clr), .load_hold(load_hold), .wr_en(wr_en), .out_en(out_en),
      .idx(idx), .din(in_0), .dout(out_0)
   );

   relu_maxpool_ch #(.POOL_W(POOL_W), .IDX_W(IDX_W)) u_ch1 (
      .clk(clk), .clr(clr), .load_hold(load_hold), .wr_en(wr_en), .out_en(out_en),
      .idx(idx), .din(in_1), .dout(out_1)
   );

   relu_maxpool_ch #(.POOL_W(POOL_W), .IDX_W(IDX_W)) u_ch2 (
      .clk(clk), .clr(clr), .load_hold(load_hold), .wr_en(wr_en), .out_en(out_en),
      .idx(idx), .din(in_2), .dout(out_2)
   );

endmodule

// File: tb/tb_relu_maxpool.sv
// tb/tb_relu_maxpool.sv - table-driven bench for relu_maxpool (4x4 and 5x5 instances)
module tb_relu_maxpool;
   import relu_maxpool_pkg::*;

   typedef struct {
      logic              sel;
      logic              rst;
      logic              st;
      logic              de;
      logic [DATA_W-1:0] d0, d1, d2;
      logic              ede;
      logic [DATA_W-1:0] e0, e1, e2;
      logic [4:0]        ec, er;
      logic              efd;
   } vec_t;

   localparam int MAX_CYCLES = 5000;

   logic clk = 1'b0;
   logic RESET = 1'b1;
   logic start = 1'b1;

   logic              de_a = 1'b0, de_b = 1'b0;
   logic [DATA_W-1:0] a0 = '0, a1 = '0, a2 = '0;
   logic [DATA_W-1:0] b0 = '0, b1 = '0, b2 = '0;

   logic              deo_a, deo_b, fd_a, fd_b;
   logic [DATA_W-1:0] oa0, oa1, oa2, ob0, ob1, ob2;
   logic [4:0]        ca, ra, cb, rb;

   vec_t vq[$];
   int   n_vec = 0;
   int   n_bad = 0;
   logic done = 1'b0;

   always #5 clk = ~clk;

   relu_maxpool #(.IN_WIDTH(4), .IN_HEIGHT(4)) dut4 (
      .clk(clk), .RESET(RESET), .start(start), .de_in(de_a),
      .in_0(a0), .in_1(a1), .in_2(a2),
      .de_out(deo_a), .out_0(oa0), .out_1(oa1), .out_2(oa2),
      .out_col(ca), .out_row(ra), .frame_done(fd_a)
   );

   relu_maxpool #(.IN_WIDTH(5), .IN_HEIGHT(5)) dut5 (
      .clk(clk), .RESET(RESET), .start(start), .de_in(de_b),
      .in_0(b0), .in_1(b1), .in_2(b2),
      .de_out(deo_b), .out_0(ob0), .out_1(ob1), .out_2(ob2),
      .out_col(cb), .out_row(rb), .frame_done(fd_b)
   );

   task automatic add(input int sel, input int rst, input int st, input int de,
                      input int d0, input int d1, input int d2,
                      input int ede, input int e0, input int e1, input int e2,
                      input int ec, input int er, input int efd);
      vec_t v;
      v.sel = sel[0]; v.rst = rst[0]; v.st = st[0]; v.de = de[0];
      v.d0 = DATA_W'(d0); v.d1 = DATA_W'(d1); v.d2 = DATA_W'(d2);
      v.ede = ede[0];
      v.e0 = DATA_W'(e0); v.e1 = DATA_W'(e1); v.e2 = DATA_W'(e2);
      v.ec = 5'(ec); v.er = 5'(er); v.efd = efd[0];
      vq.push_back(v);
   endtask

   task automatic samp(input int sel, input int d);
      add(sel, 0, 1, 1, d, d, d, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic outp(input int sel, input int d, input int e, input int ec, input int er);
      add(sel, 0, 1, 1, d, d, d, 1, e, e, e, ec, er, 0);
   endtask

   task automatic gap(input int sel, input int fd);
      add(sel, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, fd);
   endtask

   task automatic mix(input int d0, input int d1, input int d2, input int ede,
                      input int e0, input int e1, input int e2, input int ec, input int er);
      add(0, 0, 1, 1, d0, d1, d2, ede, e0, e1, e2, ec, er, 0);
   endtask

   task automatic build;
      // reset state, including data presented while reset is held
      add(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 1, 1, 1, 7, 7, 7, 0, 0, 0, 0, 0, 0, 0);
      add(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      gap(0, 0);
      // 4x4 ramp, 2-cycle gaps
      samp(0, 1); samp(0, 2); samp(0, 3); samp(0, 4); gap(0, 0); gap(0, 0);
      samp(0, 5); outp(0, 6, 6, 0, 0); samp(0, 7); outp(0, 8, 8, 1, 0); gap(0, 0); gap(0, 0);
      samp(0, 9); samp(0, 10); samp(0, 11); samp(0, 12); gap(0, 0); gap(0, 0);
      samp(0, 13); outp(0, 14, 14, 0, 1); samp(0, 15); outp(0, 16, 16, 1, 1); gap(0, 1); gap(0, 0);
      // all negative -> zeros with de_out still high
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (r[0] && c[0]) outp(0, 32'h1FFFFB, 0, c >> 1, r >> 1);
            else samp(0, 32'h1FFFFB);
         end
         gap(0, (r == 3) ? 1 : 0);
      end
      // mixed signs, 2-sample lines; ch1 negated, ch2 zero
      mix(-3, 3, 0, 0, 0, 0, 0, 0, 0); mix(7, -7, 0, 0, 0, 0, 0, 0, 0); gap(0, 0);
      mix(2, -2, 0, 0, 0, 0, 0, 0, 0); mix(-9, 9, 0, 1, 7, 9, 0, 0, 0); gap(0, 0);
      mix(4, -4, 0, 0, 0, 0, 0, 0, 0); mix(-1, 1, 0, 0, 0, 0, 0, 0, 0); gap(0, 0);
      mix(-8, 8, 0, 0, 0, 0, 0, 0, 0); mix(3, -3, 0, 1, 4, 8, 0, 0, 1); gap(0, 1);
      // 5x5 ramp on the second instance; an extra 6th sample is ignored
      samp(1, 1); samp(1, 2); samp(1, 3); samp(1, 4); samp(1, 5); gap(1, 0);
      samp(1, 6); outp(1, 7, 7, 0, 0); samp(1, 8); outp(1, 9, 9, 1, 0); samp(1, 10); samp(1, 100); gap(1, 0);
      samp(1, 11); samp(1, 12); samp(1, 13); samp(1, 14); samp(1, 15); gap(1, 0);
      samp(1, 16); outp(1, 17, 17, 0, 1); samp(1, 18); outp(1, 19, 19, 1, 1); samp(1, 20); gap(1, 0);
      samp(1, 21); samp(1, 22); samp(1, 23); samp(1, 24); samp(1, 25); gap(1, 1); gap(1, 0);
      // RESET during line 3, then a fresh frame
      samp(0, 1); samp(0, 2); samp(0, 3); samp(0, 4); gap(0, 0);
      samp(0, 5); outp(0, 6, 6, 0, 0); samp(0, 7); outp(0, 8, 8, 1, 0); gap(0, 0);
      samp(0, 9); samp(0, 10);
      add(0, 1, 1, 1, 11, 11, 11, 0, 0, 0, 0, 0, 0, 0);
      add(0, 1, 1, 1, 12, 12, 12, 0, 0, 0, 0, 0, 0, 0);
      add(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      gap(0, 0); gap(0, 0);
      samp(0, 3); samp(0, 1); samp(0, 2); samp(0, 0); gap(0, 0);
      samp(0, 0); outp(0, 0, 3, 0, 0); samp(0, 0); outp(0, 0, 2, 1, 0); gap(0, 0);
      samp(0, 5); samp(0, 6); samp(0, 7); samp(0, 8); gap(0, 0);
      samp(0, 1); outp(0, 1, 6, 0, 1); samp(0, 1); outp(0, 1, 8, 1, 1); gap(0, 1); gap(0, 0);
      // 1-cycle de_in drop mid-line: row advances, col restarts, entry 1 stays stale
      samp(0, 1); samp(0, 2); samp(0, 3); samp(0, 4); gap(0, 0); gap(0, 0);
      samp(0, 5); outp(0, 6, 6, 0, 0); gap(0, 0);
      samp(0, 7); samp(0, 8); gap(0, 0);
      samp(0, 9); outp(0, 10, 10, 0, 1); samp(0, 1); outp(0, 1, 4, 1, 1); gap(0, 1); gap(0, 0);
      // start dropped on a qualifying sample kills the pending output
      samp(0, 1); samp(0, 2); samp(0, 3); samp(0, 4); gap(0, 0);
      samp(0, 5);
      add(0, 0, 0, 1, 6, 6, 6, 0, 0, 0, 0, 0, 0, 0);
      gap(0, 0); gap(0, 0);
   endtask

   initial begin
      int cyc;
      cyc = 0;
      while (!done && cyc < MAX_CYCLES) begin
         @(posedge clk);
         cyc++;
      end
      if (!done) begin
         n_bad++;
         $display("FAIL timeout: vector run did not finish within %0d cycles", MAX_CYCLES);
         $finish;
      end
   end

   initial begin
      vec_t v;
      logic              g_de, g_fd;
      logic [DATA_W-1:0] g0, g1, g2;
      logic [4:0]        gc, gr;
      build();
      @(posedge clk);
      #1;
      n_vec++;
      if (deo_a !== 1'b0 || oa0 !== '0 || oa1 !== '0 || oa2 !== '0 ||
          ca !== 5'd0 || ra !== 5'd0 || fd_a !== 1'b0 ||
          deo_b !== 1'b0 || ob0 !== '0 || ob1 !== '0 || ob2 !== '0 ||
          cb !== 5'd0 || rb !== 5'd0 || fd_b !== 1'b0) begin
         n_bad++;
         $display("FAIL reset state: dut4 de=%0b out=%0d/%0d/%0d col=%0d row=%0d fd=%0b dut5 de=%0b out=%0d/%0d/%0d col=%0d row=%0d fd=%0b",
                  deo_a, oa0, oa1, oa2, ca, ra, fd_a, deo_b, ob0, ob1, ob2, cb, rb, fd_b);
      end
      for (int i = 0; i < vq.size(); i++) begin
         v = vq[i];
         @(negedge clk);
         RESET = v.rst;
         start = v.st;
         de_a = v.sel ? 1'b0 : v.de;
         a0 = v.sel ? '0 : v.d0; a1 = v.sel ? '0 : v.d1; a2 = v.sel ? '0 : v.d2;
         de_b = v.sel ? v.de : 1'b0;
         b0 = v.sel ? v.d0 : '0; b1 = v.sel ? v.d1 : '0; b2 = v.sel ? v.d2 : '0;
         @(posedge clk);
         #1;
         if (v.sel) begin
            g_de = deo_b; g0 = ob0; g1 = ob1; g2 = ob2; gc = cb; gr = rb; g_fd = fd_b;
         end else begin
            g_de = deo_a; g0 = oa0; g1 = oa1; g2 = oa2; gc = ca; gr = ra; g_fd = fd_a;
         end
         n_vec++;
         if (g_de !== v.ede || g0 !== v.e0 || g1 !== v.e1 || g2 !== v.e2 ||
             gc !== v.ec || gr !== v.er || g_fd !== v.efd) begin
            n_bad++;
            $display("FAIL vec%0d dut%0d: got de=%0b out=%0d/%0d/%0d col=%0d row=%0d fd=%0b, want de=%0b out=%0d/%0d/%0d col=%0d row=%0d fd=%0b",
                     i, v.sel ? 5 : 4, g_de, g0, g1, g2, gc, gr, g_fd,
                     v.ede, v.e0, v.e1, v.e2, v.ec, v.er, v.efd);
         end
      end
      done = 1'b1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      if (n_bad == 0) $display("PASS");
      else $display("FAIL");
      $finish;
   end

endmodule
